burst_mem_slave: RTL and testbench

// - Parametrised burst-capable memory slave; successor to the fixed 32-bit/4-bit-address burst pair.
// - Accepts one read or write burst command, then transfers io_length beats to or from an internal DEPTH-word array.
// - Adds INCR/WRAP addressing, read back-pressure (io_rready), command error reporting and a done pulse.
// - Sits behind the bus master FSM in the top-level interconnect.

---
 rtl/burst_pkg.sv | 34 +++
 rtl/burst_addr_gen.sv | 62 ++++++
 rtl/burst_mem_slave.sv | 140 ++++++++++++++
 tb/tb_burst_mem_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared definitions for the burst memory slave.
// - state_t      : controller states
// - BURST_INCR / BURST_WRAP : values of the io_wrap mode bit
// - next_addr()  : next word address for INCR or WRAP bursts (32-bit, caller truncates)
// - is_pow2()    : legality test for WRAP burst lengths
package burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic BURST_INCR = 1'b0;
    localparam logic BURST_WRAP = 1'b1;

    // WRAP keeps the high bits of the len-aligned window and increments only
    // the low bits, so the burst cycles inside that window.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [31:0] len,
                                              input logic        wrap);
        logic [31:0] mask;
        mask = len - 32'd1;
        if (wrap == BURST_WRAP) begin
            return (addr & ~mask) | ((addr + 32'd1) & mask);
        end
        return addr + 32'd1;
    endfunction

    function automatic logic is_pow2(input logic [31:0] len);
        return (len != 32'd0) && ((len & (len - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Address and beat counter for one burst.
// Ports:
// - clock, reset : clock and synchronous active-high reset
// - i_load       : capture start address, length and mode
// - i_advance    : one beat done; step address, decrement remaining beats
// - i_addr/i_len/i_wrap : burst command fields captured on i_load
// - o_addr       : current beat address
// - o_last       : exactly one beat remains
// - o_empty      : no beats remain
module burst_addr_gen
    import burst_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_wrap,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_empty
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_beats;
    logic [LEN_W-1:0]  r_len;
    logic              r_wrap;
    logic [31:0]       w_next_full;
    logic              w_unused_hi;

    assign w_next_full = next_addr({{(32-ADDR_W){1'b0}}, r_addr},
                                   {{(32-LEN_W){1'b0}}, r_len},
                                   r_wrap);
    // Bits above ADDR_W fall away: this is the mod-DEPTH wrap of INCR.
    assign w_unused_hi = ^w_next_full[31:ADDR_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            r_beats <= '0;
            r_len   <= '0;
            r_wrap  <= BURST_INCR;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_beats <= i_len;
            r_len   <= i_len;
            r_wrap  <= i_wrap;
        end else if (i_advance) begin
            r_addr  <= w_next_full[ADDR_W-1:0];
            r_beats <= r_beats - 1'b1;
        end
    end

    assign o_addr  = r_addr;
    assign o_last  = (r_beats == LEN_W'(1));
    assign o_empty = (r_beats == '0);

endmodule

// File: rtl/burst_mem_slave.sv
// Burst-capable memory slave: one read or write burst command, then io_length
// beats to/from an internal DEPTH-word array with INCR or WRAP addressing.
// Ports:
// - clock, reset              : clock, synchronous active-high reset
// - io_wr, io_rd              : burst commands, sampled in IDLE
// - io_address, io_length, io_wrap : burst start, beat count, mode
// - io_wdata, io_wvalid       : write beats
// - io_ready                  : command accept (IDLE) / write beat accept (WRITE)
// - io_rdata, io_rddatavalid, io_rready : read beats with back-pressure
// - io_busy                   : a burst is in progress
// - io_done                   : 1-cycle pulse after the last beat
// - io_cmd_err                : 1-cycle pulse on a rejected command
module burst_mem_slave
    import burst_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 4,
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [ADDR_W-1:0] io_address,
    input  logic [LEN_W-1:0]  io_length,
    input  logic              io_wrap,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic              io_wvalid,
    output logic              io_ready,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rddatavalid,
    input  logic              io_rready,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_cmd_err
);

    localparam int               DEPTH     = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t            r_state;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rddatavalid;
    logic              r_done;
    logic              r_cmd_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic              w_empty;
    logic              w_cmd;
    logic              w_cmd_legal;
    logic              w_load;
    logic              w_wr_beat;
    logic              w_rd_beat;
    logic              w_rd_end;

    assign w_cmd       = io_wr | io_rd;
    assign w_cmd_legal = !(io_wr && io_rd)
                      && (io_length != '0) && (io_length <= MAX_LEN_L)
                      && (!io_wrap || is_pow2({{(32-LEN_W){1'b0}}, io_length}));
    assign w_load      = (r_state == IDLE) && w_cmd && w_cmd_legal;
    assign w_wr_beat   = (r_state == WRITE) && io_wvalid;
    // A new read beat may be fetched when the output slot is empty or being drained.
    assign w_rd_beat   = (r_state == READ) && !w_empty && (!r_rddatavalid || io_rready);
    assign w_rd_end    = (r_state == READ) && w_empty && r_rddatavalid && io_rready;

    burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_load),
        .i_advance (w_wr_beat | w_rd_beat),
        .i_addr    (io_address),
        .i_len     (io_length),
        .i_wrap    (io_wrap),
        .o_addr    (w_addr),
        .o_last    (w_last),
        .o_empty   (w_empty)
    );

    // Array keeps its contents across reset; a beat on the reset edge is dropped.
    always_ff @(posedge clock) begin
        if (w_wr_beat && !reset) begin
            r_mem[w_addr] <= io_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rdata       <= '0;
            r_rddatavalid <= 1'b0;
            r_done        <= 1'b0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd) begin
                        if (w_cmd_legal) begin
                            r_state <= io_wr ? WRITE : READ;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (io_wvalid && w_last) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                READ: begin
                    if (w_rd_beat) begin
                        r_rdata       <= r_mem[w_addr];
                        r_rddatavalid <= 1'b1;
                    end else if (w_rd_end) begin
                        r_rddatavalid <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_ready       = (r_state != READ);
    assign io_busy        = (r_state != IDLE);
    assign io_rdata       = r_rdata;
    assign io_rddatavalid = r_rddatavalid;
    assign io_done        = r_done;
    assign io_cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_burst_mem_slave.sv
module tb_burst_mem_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [3:0]  io_address = '0;
    logic [3:0]  io_length = '0;
    logic        io_wrap = 1'b0;
    logic [31:0] io_wdata = '0;
    logic        io_wvalid = 1'b0;
    logic        io_ready;
    logic [31:0] io_rdata;
    logic        io_rddatavalid;
    logic        io_rready = 1'b0;
    logic        io_busy;
    logic        io_done;
    logic        io_cmd_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [16];

    burst_mem_slave #(.DATA_W(32), .ADDR_W(4), .MAX_LEN(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_wr          (io_wr),
        .io_rd          (io_rd),
        .io_address     (io_address),
        .io_length      (io_length),
        .io_wrap        (io_wrap),
        .io_wdata       (io_wdata),
        .io_wvalid      (io_wvalid),
        .io_ready       (io_ready),
        .io_rdata       (io_rdata),
        .io_rddatavalid (io_rddatavalid),
        .io_rready      (io_rready),
        .io_busy        (io_busy),
        .io_done        (io_done),
        .io_cmd_err     (io_cmd_err)
    );

    always #5 clock = ~clock;

    // Reference address step: INCR modulo 16, WRAP inside the len-aligned window.
    function automatic int model_next(int a, int len, bit wrap);
        int base;
        if (!wrap) return (a + 1) % 16;
        base = (a / len) * len;
        return base + ((a - base + 1) % len);
    endfunction

    task automatic issue_cmd(bit wr, bit rd, int addr, int len, bit wrap);
        io_wr      = wr;
        io_rd      = rd;
        io_address = 4'(addr);
        io_length  = 4'(len);
        io_wrap    = wrap;
        @(posedge clock); #1;
        io_wr = 1'b0;
        io_rd = 1'b0;
    endtask

    // Drives one write burst; updates the model on every accepted beat.
    task automatic do_write(int addr, int len, bit wrap, bit gaps,
                            input logic [31:0] d[$], output int dones, output int beats);
        int a;
        int cyc;
        issue_cmd(1'b1, 1'b0, addr, len, wrap);
        a = addr; beats = 0; dones = 0; cyc = 0;
        while (beats < len && cyc < 100) begin
            io_wvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            io_wdata  = d[beats];
            @(posedge clock); #1;
            cyc++;
            if (io_done) dones++;
            if (io_wvalid) begin
                mem_m[a] = d[beats];
                a = model_next(a, len, wrap);
                beats++;
            end
        end
        io_wvalid = 1'b0;
        @(posedge clock); #1;
        if (io_done) dones++;
    endtask

    // Drives one read burst. mode 0: rready=1, 1: random, 2: stall 2 cycles on beat 2.
    task automatic do_read(int addr, int len, bit wrap, int mode,
                           output logic [31:0] got[$], output int first_lat,
                           output int last_cyc, output int dones, output int unstable);
        int cyc;
        int hold;
        int tail;
        logic pv, pr;
        logic [31:0] pd;
        issue_cmd(1'b0, 1'b1, addr, len, wrap);
        got = {}; first_lat = -1; last_cyc = -1; dones = 0; unstable = 0;
        cyc = 0; hold = 0; tail = 0;
        while (cyc < 150 && tail < 3) begin
            if (mode == 0) io_rready = 1'b1;
            else if (mode == 1) io_rready = 1'($urandom_range(0, 1));
            else if (got.size() == 1 && io_rddatavalid && hold < 2) begin
                io_rready = 1'b0; hold++;
            end else io_rready = 1'b1;
            pv = io_rddatavalid; pd = io_rdata; pr = io_rready;
            @(posedge clock); #1;
            cyc++;
            if (pv && pr) begin
                got.push_back(pd);
                if (got.size() == len) last_cyc = cyc;
            end
            if (pv && !pr && (io_rddatavalid !== 1'b1 || io_rdata !== pd)) unstable++;
            if (io_rddatavalid && first_lat < 0) first_lat = cyc;
            if (io_done) dones++;
            if (got.size() >= len) tail++;
        end
        io_rready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (io_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", io_ready); end
        total++; if (io_rddatavalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", io_rddatavalid); end
        total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", io_busy); end
        total++; if (io_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", io_done); end
        total++; if (io_cmd_err !== 1'b0) begin bad++; $display("FAIL reset_cmd_err got=%b want=0", io_cmd_err); end
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", io_rdata); end
        reset = 1'b0;
        @(posedge clock); #1;
        $display("reset: ready=%b busy=%b rdata=%h", io_ready, io_busy, io_rdata);
    endtask

    task automatic test_incr;
        logic [31:0] d[$];
        logic [31:0] got[$];
        int dn, bt, fl, lc, us, a;
        d = {32'hA, 32'hB, 32'hC, 32'hD};
        do_write(6, 4, 1'b0, 1'b0, d, dn, bt);
        total++; if (dn != 1) begin bad++; $display("FAIL incr_wr_done got=%0d want=1", dn); end
        total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL incr_wr_busy got=%b want=0", io_busy); end
        do_read(6, 4, 1'b0, 0, got, fl, lc, dn, us);
        $display("incr read: addr=6 len=4 beats=%0d first=%0d last=%0d done=%0d", got.size(), fl, lc, dn);
        total++; if (fl != 1) begin bad++; $display("FAIL incr_first_latency got=%0d want=1", fl); end
        total++; if (lc != 5) begin bad++; $display("FAIL incr_back_to_back last=%0d want=5", lc); end
        total++; if (dn != 1) begin bad++; $display("FAIL incr_rd_done got=%0d want=1", dn); end
        total++; if (got.size() != 4) begin bad++; $display("FAIL incr_rd_count got=%0d want=4", got.size()); end
        a = 6;
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total++;
            if (got[i] !== d[i]) begin bad++; $display("FAIL incr_rd_beat%0d got=%h want=%h", i, got[i], d[i]); end
            a = model_next(a, 4, 1'b0);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d[$];
        logic [31:0] got[$];
        logic [31:0] want[4];
        int dn, bt, fl, lc, us;
        d = {32'hA1, 32'hB1, 32'hC1, 32'hD1};
        want = '{32'hC1, 32'hD1, 32'hA1, 32'hB1};
        do_write(6, 4, 1'b1, 1'b0, d, dn, bt);
        total++; if (dn != 1) begin bad++; $display("FAIL wrap_wr_done got=%0d want=1", dn); end
        do_read(4, 4, 1'b0, 0, got, fl, lc, dn, us);
        $display("wrap write 6/4 then read 4/4: beats=%0d done=%0d", got.size(), dn);
        total++; if (got.size() != 4) begin bad++; $display("FAIL wrap_rd_count got=%0d want=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total++;
            if (got[i] !== want[i]) begin bad++; $display("FAIL wrap_rd_beat%0d got=%h want=%h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] got[$];
        int fl, lc, dn, us, a;
        do_read(4, 4, 1'b0, 2, got, fl, lc, dn, us);
        $display("backpressure read 4/4: beats=%0d last=%0d done=%0d unstable=%0d", got.size(), lc, dn, us);
        total++; if (us != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d want=0", us); end
        total++; if (dn != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", dn); end
        total++; if (lc != 7) begin bad++; $display("FAIL bp_last_cycle got=%0d want=7", lc); end
        total++; if (got.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got.size()); end
        a = 4;
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total++;
            if (got[i] !== mem_m[a]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, got[i], mem_m[a]); end
            a = model_next(a, 4, 1'b0);
        end
    endtask

    task automatic test_incr_wraparound;
        logic [31:0] d[$];
        logic [31:0] got[$];
        int dn, bt, fl, lc, us;
        d = {32'hE, 32'hF};
        do_write(15, 2, 1'b0, 1'b0, d, dn, bt);
        do_read(0, 1, 1'b0, 0, got, fl, lc, dn, us);
        total++; if (got.size() != 1 || got[0] !== 32'hF) begin
            bad++; $display("FAIL wraparound_mem0 got=%h want=0000000f", got.size() > 0 ? got[0] : 32'hx);
        end
        do_read(15, 1, 1'b0, 0, got, fl, lc, dn, us);
        total++; if (got.size() != 1 || got[0] !== 32'hE) begin
            bad++; $display("FAIL wraparound_mem15 got=%h want=0000000e", got.size() > 0 ? got[0] : 32'hx);
        end
        $display("incr wraparound: write 15/2 checked mem[15], mem[0]");
    endtask

    task automatic test_errors;
        int wr_t[4]   = '{1, 1, 1, 1};
        int rd_t[4]   = '{1, 0, 0, 0};
        int len_t[4]  = '{4, 0, 9, 3};
        int wrap_t[4] = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            issue_cmd(1'(wr_t[k]), 1'(rd_t[k]), 3, len_t[k], 1'(wrap_t[k]));
            $display("error cmd %0d: len=%0d wrap=%0d cmd_err=%b busy=%b", k, len_t[k], wrap_t[k], io_cmd_err, io_busy);
            total++; if (io_cmd_err !== 1'b1) begin bad++; $display("FAIL err%0d_pulse got=%b want=1", k, io_cmd_err); end
            total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL err%0d_busy got=%b want=0", k, io_busy); end
            @(posedge clock); #1;
            total++; if (io_cmd_err !== 1'b0) begin bad++; $display("FAIL err%0d_one_cycle got=%b want=0", k, io_cmd_err); end
        end
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] got[$];
        logic [31:0] d0, d1;
        int fl, lc, dn, us;
        d0 = $urandom; d1 = $urandom;
        issue_cmd(1'b1, 1'b0, 2, 4, 1'b0);
        io_wvalid = 1'b1; io_wdata = d0;
        @(posedge clock); #1;
        io_wdata = d1;
        @(posedge clock); #1;
        mem_m[2] = d0; mem_m[3] = d1;
        io_wvalid = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        $display("reset mid-write: busy=%b ready=%b", io_busy, io_ready);
        total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", io_busy); end
        total++; if (io_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", io_ready); end
        do_read(2, 2, 1'b0, 0, got, fl, lc, dn, us);
        total++; if (got.size() != 2) begin bad++; $display("FAIL midrst_count got=%0d want=2", got.size()); end
        for (int i = 0; i < got.size() && i < 2; i++) begin
            total++;
            if (got[i] !== mem_m[2 + i]) begin bad++; $display("FAIL midrst_beat%0d got=%h want=%h", i, got[i], mem_m[2 + i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] d[$];
        logic [31:0] got[$];
        int addr, len, dn, bt, fl, lc, us, a, errs;
        bit wrap;
        for (int it = 0; it < 25; it++) begin
            wrap = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 15);
            len  = wrap ? (1 << $urandom_range(0, 3)) : $urandom_range(1, 8);
            d = {};
            for (int i = 0; i < len; i++) d.push_back($urandom);
            do_write(addr, len, wrap, 1'b1, d, dn, bt);
            total++; if (dn != 1 || bt != len) begin bad++; $display("FAIL rnd%0d_write done=%0d beats=%0d want 1/%0d", it, dn, bt, len); end
            do_read(addr, len, wrap, 1, got, fl, lc, dn, us);
            errs = 0; a = addr;
            for (int i = 0; i < len; i++) begin
                if (i >= got.size() || got[i] !== mem_m[a]) errs++;
                a = model_next(a, len, wrap);
            end
            $display("random %0d: addr=%0d len=%0d wrap=%0d beats=%0d done=%0d errs=%0d", it, addr, len, wrap, got.size(), dn, errs);
            total++; if (errs != 0 || got.size() != len) begin bad++; $display("FAIL rnd%0d_read errs=%0d beats=%0d want 0/%0d", it, errs, got.size(), len); end
            total++; if (dn != 1 || us != 0) begin bad++; $display("FAIL rnd%0d_done done=%0d unstable=%0d want 1/0", it, dn, us); end
        end
    endtask

    initial begin
        test_reset;
        test_incr;
        test_wrap;
        test_backpressure;
        test_incr_wraparound;
        test_errors;
        test_reset_mid_write;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
